// File: rtl/hilo_mult_unit.sv
// Iterative radix-2 shift-add multiplier that owns the HI/LO register pair and serves mfhi/mflo.
// Define HILO_MULTU_EN to add the unsignedop input (multu support); otherwise every multiply is signed.
//
// state  | meaning
// IDLE   | waiting for start; HI/LO stable
// RUN    | one multiplier bit consumed per clock, WIDTH clocks
// FINISH | sign-correct the accumulator into HI/LO
module hilo_mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
`ifdef HILO_MULTU_EN
    input  logic             unsignedop,
`endif
    input  logic [1:0]       move,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] moveresult
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t             state, state_next;
    logic [CW-1:0]      counter;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic               sign;

    logic               op_unsigned;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               sign_in;
    logic [2*WIDTH-1:0] product;

`ifdef HILO_MULTU_EN
    assign op_unsigned = unsignedop;
`else
    assign op_unsigned = 1'b0;
`endif

    // The most negative operand negates to itself, which is exactly 2^(WIDTH-1) read as unsigned.
    always_comb begin
        mag_a   = (!op_unsigned && srca[WIDTH-1]) ? (~srca + 1'b1) : srca;
        mag_b   = (!op_unsigned && srcb[WIDTH-1]) ? (~srcb + 1'b1) : srcb;
        sign_in = !op_unsigned && (srca[WIDTH-1] ^ srcb[WIDTH-1]);
        product = sign ? (~acc + 1'b1) : acc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (counter == CW'(WIDTH - 1)) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == FINISH);
    end

    // The multiplicand register shifts left so it is always aligned with the current multiplier bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            sign    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand   <= {{WIDTH{1'b0}}, mag_a};
                        mplier  <= mag_b;
                        sign    <= sign_in;
                        acc     <= '0;
                        counter <= '0;
                    end
                end
                RUN: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    counter <= counter + 1'b1;
                end
                FINISH: begin
                    {hi, lo} <= product;
                end
                default: ;
            endcase
        end
    end

    // Only a new mult or an HI/LO read has to wait; unrelated instructions flow past a running multiply.
    assign stall = busy & (start | (move == 2'b10) | (move == 2'b01));

    always_comb begin
        case (move)
            2'b10:   moveresult = hi;
            2'b01:   moveresult = lo;
            default: moveresult = '0;
        endcase
    end

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Scoreboard bench for hilo_mult_unit: expected {hi,lo} queued at issue, compared when the multiply completes.
// Extra multu cases are compiled in when HILO_MULTU_EN is defined.
module tb_hilo_mult_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] srca, srcb;
    logic [1:0]   move;
    logic         busy, stall, done;
    logic [W-1:0] hi, lo, moveresult;
`ifdef HILO_MULTU_EN
    logic         unsignedop;
`endif

    int errors = 0;
    int checks = 0;
    logic [2*W-1:0] sb_q[$];

    hilo_mult_unit #(.WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .srca(srca),
        .srcb(srcb),
`ifdef HILO_MULTU_EN
        .unsignedop(unsignedop),
`endif
        .move(move),
        .busy(busy),
        .stall(stall),
        .done(done),
        .hi(hi),
        .lo(lo),
        .moveresult(moveresult)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic uns);
        if (uns) return {32'b0, a} * {32'b0, b};
        return {{32{a[W-1]}}, a} * {{32{b[W-1]}}, b};
    endfunction

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic uns,
                         input logic [63:0] exp);
        @(negedge clk);
        start = 1'b1;
        srca  = a;
        srcb  = b;
`ifdef HILO_MULTU_EN
        unsignedop = uns;
`endif
        sb_q.push_back(exp);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pop_compare(input string tag);
        logic [63:0] exp;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd1);
        end else begin
            exp = sb_q.pop_front();
            check({tag, "_hilo"}, {hi, lo}, exp);
        end
    endtask

    // Counts busy/done cycles after issue; optionally re-presents start mid-run, which must be ignored.
    task automatic wait_result(input string tag, input logic poke_start);
        int cnt  = 0;
        int dcnt = 0;
        int dcyc = 0;
        while (busy && cnt < 200) begin
            cnt++;
            if (done) begin
                dcnt++;
                dcyc = cnt;
            end
            if (poke_start && cnt == 4) begin
                start = 1'b1;
                srca  = 32'd99;
                srcb  = 32'd77;
                #1 check({tag, "_stall_on_start"}, 64'(stall), 64'd1);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, "_busy_cycles"}, 64'(cnt), 64'd33);
        check({tag, "_done_cycle"}, 64'(dcyc), 64'd33);
        check({tag, "_done_count"}, 64'(dcnt), 64'd1);
        pop_compare(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int stall_bad;
        logic [W-1:0] ra, rb;

        reset = 1'b1;
        start = 1'b0;
        srca  = '0;
        srcb  = '0;
        move  = 2'b00;
`ifdef HILO_MULTU_EN
        unsignedop = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);

        issue(32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F);
        wait_result("m3x5", 1'b1);
        check("m3x5_lo", 64'(lo), 64'h0000_000F);

        issue(32'hFFFF_FFFF, 32'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_result("neg1x1", 1'b0);

        issue(32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000);
        wait_result("minxmin", 1'b0);

        // Abort a 7*9 ten cycles in: HI/LO must clear, not keep the previous product.
        issue(32'd7, 32'd9, 1'b0, 64'd63);
        void'(sb_q.pop_back());
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_idle", 64'(busy), 64'd0);

        issue(32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000);
        move = 2'b00;
        #1 check("add_nostall", 64'(stall), 64'd0);
        move = 2'b11;
        #1 check("mv11_nostall", 64'(stall), 64'd0);
        move = 2'b00;
        repeat (4) @(negedge clk);
        move      = 2'b10;
        cnt       = 5;
        stall_bad = 0;
        while (busy && cnt < 200) begin
            #1 if (!stall) stall_bad++;
            @(negedge clk);
            cnt++;
        end
        check("mfhi_busy_end", 64'(cnt), 64'd34);
        check("mfhi_stall_held", 64'(stall_bad), 64'd0);
        #1;
        check("mfhi_stall_rel", 64'(stall), 64'd0);
        check("mfhi_result", 64'(moveresult), 64'h1);
        move = 2'b01;
        #1 check("mflo_result", 64'(moveresult), 64'h0);
        move = 2'b00;
        #1 check("nomove_result", 64'(moveresult), 64'h0);
        pop_compare("shift16");

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i == 0) ra = 32'h7FFF_FFFF;
            if (i == 1) rb = 32'd0;
            issue(ra, rb, 1'b0, model(ra, rb, 1'b0));
            wait_result("rand", 1'b0);
        end

`ifdef HILO_MULTU_EN
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001);
        wait_result("multu_max", 1'b0);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'h0000_0000_0000_0001);
        wait_result("mult_neg1sq", 1'b0);
        ra = $urandom;
        rb = $urandom | 32'h8000_0000;
        issue(ra, rb, 1'b1, model(ra, rb, 1'b1));
        wait_result("multu_rand", 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
